// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end feeding the stage-0 decoder.
// It owns the fetch PC and issues at most one read per cycle to a
// synchronous instruction memory that returns data one cycle later. Returned
// words are buffered with their addresses in a small FIFO.
//
// Handshakes:
//   memory side : mem_req/mem_addr form a request in cycle N. mem_data is
//                 valid in cycle N+1. There is no back-pressure from memory.
//                 A request is only made when a FIFO slot is free for its
//                 response (occupancy + inflight < DEPTH).
//   decoder side: ir_valid/ir_ready form a strict valid/ready pair. The head
//                 entry is consumed on a clock edge where ir_valid && ir_ready
//                 is high and no redirect is present. ir/ir_pc stay stable
//                 while ir_valid is high and not consumed.
//
// A redirect flushes the FIFO, toggles the epoch so any response still in
// flight is ignored, and restarts fetch at redirect_pc.
module ifetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     mem_req,
  output logic [15:0]              mem_addr,
  input  logic [15:0]              mem_data,
  output logic                     ir_valid,
  output logic [15:0]              ir,
  output logic [15:0]              ir_pc,
  input  logic                     ir_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // Architectural state
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          inflight_q, inflight_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_epoch_q, inflight_epoch_d;
  logic          epoch_q, epoch_d;

  // FIFO storage; contents are only observed through occupancy-gated reads,
  // so no reset is needed.
  logic [15:0]   word_q [DEPTH];
  logic [15:0]   pc_q   [DEPTH];

  // Per-cycle events
  logic [OW-1:0] fill;
  logic          issue;
  logic          capture;
  logic          deq;

  // Request, capture and dequeue decisions plus head-of-queue outputs
  always_comb begin
    fill     = occ_q + OW'(inflight_q);
    issue    = !reset && !halt && !redirect && (fill < OW'(DEPTH));
    capture  = inflight_q && (inflight_epoch_q == epoch_q) && !redirect;
    ir_valid = (occ_q != '0) && !halt;
    deq      = ir_valid && ir_ready;

    mem_req   = issue;
    mem_addr  = fetch_pc_q;
    occupancy = occ_q;

    ir    = 16'h0000;
    ir_pc = 16'h0000;
    if (occ_q != '0) begin
      ir    = word_q[rd_ptr_q];
      ir_pc = pc_q[rd_ptr_q];
    end
  end

  // Next-state computation; a redirect overrides every normal update
  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    occ_d            = occ_q;
    inflight_d       = issue;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q;

    if (issue) begin
      fetch_pc_d       = fetch_pc_q + 16'd1;
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
    end

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      occ_d      = '0;
      epoch_d    = !epoch_q;
    end else begin
      if (deq)     rd_ptr_d = rd_ptr_q + AW'(1);
      if (capture) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({capture, deq})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q       <= 16'h0000;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      occ_q            <= '0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= 16'h0000;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      occ_q            <= occ_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  // Write the returning word and its address into the tail slot
  always_ff @(posedge clk) begin
    if (capture && !reset) begin
      word_q[wr_ptr_q] <= mem_data;
      pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule
